exu_ctrl: RTL and testbench
===========================

EXU_CTRL -- requirements
Module: exu_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 3: nominal multiplier latency in cycles; documentation only, no functional effect.
REQ-002 Parameter TIMEOUT, default 200: maximum cycles spent in MUL_WAIT/DIV_WAIT before error completion.
REQ-003 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- issue_valid  in  1  decode presents an op.
- issue_ready  out  1  controller accepts an op.
- issue_op  in  ALUOP_WIDTH  ALU opcode.
- issue_brsel  in  BRSEL_WIDTH  branch select; 0 means not a branch.
- issue_a, issue_b, issue_pc, issue_imm  in  64 each  operands.
- flush  in  1  pipeline kill.
- op_a, op_b, op_pc, op_imm  out  64 each  latched operands to units.
- op_code  out  ALUOP_WIDTH  latched opcode.
- op_brsel  out  BRSEL_WIDTH  latched branch select.
- alu_start, mul_start, div_start  out  1 each  one-cycle start pulses.
- div_signed  out  1  signed divide/remainder.
- alu_ok  in  1  ALU/branch result valid.
- alu_res, br_res  in  64 each  ALU result, branch target.
- br_redirect  in  1  branch taken.
- mul_ok  in  1  multiplier result valid.
- mul_res  in  64  multiplier result.
- div_ok  in  1  divider result valid.
- div_quot, div_rem  in  64 each  quotient, remainder.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  64  result.
- wb_redirect  out  1  branch redirect.
- wb_target  out  64  redirect target.
- wb_err  out  1  unit timeout.
- busy  out  1  state is not IDLE.

Function
REQ-004 States: IDLE, ALU_WAIT, MUL_WAIT, DIV_WAIT, DONE, DRAIN.
REQ-005 issue_ready = (state==IDLE) && !flush; an op is accepted when issue_valid && issue_ready.
REQ-006 Op class on acceptance: issue_op==OP_MUL -> MUL_WAIT; OP_DIV/OP_DIVU/OP_REM/OP_REMU -> DIV_WAIT; any other opcode (including branches) -> ALU_WAIT.
REQ-007 On acceptance, all issue_* values are latched into op_*; op_* hold until the next acceptance.
REQ-008 The start pulse of the selected unit is asserted for exactly the one cycle after acceptance; the other start pulses stay 0.
REQ-009 div_signed = 1 for OP_DIV and OP_REM, 0 otherwise; it is valid while div_start is high.
REQ-010 Completion signals: ALU_WAIT completes on alu_ok, MUL_WAIT on mul_ok, DIV_WAIT on div_ok; an ok from any non-selected unit is ignored.
REQ-011 Earliest completion is on the start cycle, so wb_valid rises no earlier than 2 cycles after acceptance.
REQ-012 Captured result: wb_data = alu_res, mul_res, div_quot (DIV/DIVU) or div_rem (REM/REMU); wb_redirect = br_redirect && op_brsel!=0 (otherwise 0); wb_target = br_res; all captured on the completion edge, with transition to DONE.
REQ-013 In DONE, wb_valid = !flush; wb_* are held stable until wb_valid && wb_ready, then the state returns to IDLE, so the next acceptance is possible on the following cycle.
REQ-014 Timeout counter:
- 8-bit counter, cleared on entry to MUL_WAIT/DIV_WAIT, incremented each cycle in those states.
- When it reaches TIMEOUT-1 with no ok: go to DONE with wb_err=1, wb_data=0, wb_redirect=0.
- An ok arriving on that same cycle wins; wb_err stays 0.
REQ-015 Flush handling (flush has priority over every other event in the same cycle):
- From IDLE, ALU_WAIT or DONE: go to IDLE; no writeback.
- From MUL_WAIT/DIV_WAIT with no ok this cycle: go to DRAIN.
- From MUL_WAIT/DIV_WAIT with the ok this cycle: go to IDLE.
REQ-016 DRAIN waits for the pending unit's ok (discarded) or a timeout, then goes to IDLE; issue_ready=0 throughout, so a stale ok can never complete a new op.
REQ-017 busy = (state != IDLE).

Reset
REQ-018 On rst==0, asynchronously: state=IDLE, counter=0, all start pulses 0, wb_valid=0, wb_err=0, wb_redirect=0, wb_data=0, wb_target=0, op_*=0, div_signed=0.
REQ-019 Reset asserted mid-operation abandons the op; unit ok pulses arriving after reset release while in IDLE are ignored.

Structure
REQ-020 OP_MUL=15, OP_DIV=16, OP_DIVU=17, OP_REM=18, OP_REMU=19, ALUOP_WIDTH, BRSEL_WIDTH and the state enum typedef live in the shared param package.
REQ-021 A single sub-module, exu_timeout_ctr (clear, enable, expired), is natural; everything else stays in exu_ctrl.

Verification
REQ-022 Issue ADD, alu_ok on the start cycle, wb_ready=1 -> alu_start pulses once; wb_valid rises 2 cycles after acceptance; wb_data=alu_res.
REQ-023 Issue OP_REM with a=-7, b=2, div_ok after 10 cycles with div_rem=-1 -> div_signed=1; wb_data=-1; wb_err=0.
REQ-024 Issue OP_MUL, flush 1 cycle later, mul_ok 2 cycles after that -> state goes DRAIN, then IDLE; wb_valid never asserts; issue_ready low until the drain ends.
REQ-025 Issue OP_DIVU, never assert div_ok -> DONE after TIMEOUT cycles; wb_err=1; wb_data=0.
REQ-026 Hold wb_ready=0 for 5 cycles in DONE while issue_valid=1 -> wb_* stable; issue_ready=0; a second op is accepted on the cycle after the wb handshake.
REQ-027 Pull rst low during DIV_WAIT -> all outputs reach their reset values immediately; a later div_ok is ignored.

Source files
------------

// File: rtl/exu_ctrl_pkg.sv
// Shared opcode constants, widths, state encoding and op-class helpers
// for the execute-unit controller.
package exu_ctrl_pkg;

  localparam int ALUOP_WIDTH = 5;
  localparam int BRSEL_WIDTH = 3;

  localparam logic [ALUOP_WIDTH-1:0] OP_ADD  = 5'd0;
  localparam logic [ALUOP_WIDTH-1:0] OP_MUL  = 5'd15;
  localparam logic [ALUOP_WIDTH-1:0] OP_DIV  = 5'd16;
  localparam logic [ALUOP_WIDTH-1:0] OP_DIVU = 5'd17;
  localparam logic [ALUOP_WIDTH-1:0] OP_REM  = 5'd18;
  localparam logic [ALUOP_WIDTH-1:0] OP_REMU = 5'd19;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALU_WAIT = 3'd1,
    MUL_WAIT = 3'd2,
    DIV_WAIT = 3'd3,
    DONE     = 3'd4,
    DRAIN    = 3'd5
  } exu_state_e;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2
  } exu_unit_e;

  // Which execution unit services an opcode; branches go to the ALU.
  function automatic exu_unit_e op_unit(input logic [ALUOP_WIDTH-1:0] op);
    exu_unit_e u;
    case (op)
      OP_MUL:                          u = UNIT_MUL;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: u = UNIT_DIV;
      default:                         u = UNIT_ALU;
    endcase
    return u;
  endfunction

  function automatic logic op_div_signed(input logic [ALUOP_WIDTH-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [ALUOP_WIDTH-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exu_timeout_ctr.sv
// Wait-cycle counter for the multi-cycle units. Cleared when an op is
// accepted, counts while enabled and saturates at the limit so that the
// expired flag stays up if the controller lingers (e.g. entering DRAIN).
module exu_timeout_ctr #(
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // Next count: clear wins, otherwise count up until the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exu_ctrl.sv
// Execute-stage controller: accepts one op at a time from decode, launches
// the ALU, multiplier or divider, captures the result and holds it for
// writeback. Flushes abandon the op; a flushed multi-cycle op is drained
// so that its late ok can never complete a newer op.
module exu_ctrl
  import exu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [ALUOP_WIDTH-1:0] issue_op,
  input  logic [BRSEL_WIDTH-1:0] issue_brsel,
  input  logic [63:0]            issue_a,
  input  logic [63:0]            issue_b,
  input  logic [63:0]            issue_pc,
  input  logic [63:0]            issue_imm,
  input  logic                   flush,
  output logic [63:0]            op_a,
  output logic [63:0]            op_b,
  output logic [63:0]            op_pc,
  output logic [63:0]            op_imm,
  output logic [ALUOP_WIDTH-1:0] op_code,
  output logic [BRSEL_WIDTH-1:0] op_brsel,
  output logic                   alu_start,
  output logic                   mul_start,
  output logic                   div_start,
  output logic                   div_signed,
  input  logic                   alu_ok,
  input  logic [63:0]            alu_res,
  input  logic [63:0]            br_res,
  input  logic                   br_redirect,
  input  logic                   mul_ok,
  input  logic [63:0]            mul_res,
  input  logic                   div_ok,
  input  logic [63:0]            div_quot,
  input  logic [63:0]            div_rem,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [63:0]            wb_data,
  output logic                   wb_redirect,
  output logic [63:0]            wb_target,
  output logic                   wb_err,
  output logic                   busy
);

  // MUL_LAT only documents the expected multiplier latency.
  logic unused_mul_lat;
  assign unused_mul_lat = (MUL_LAT > 0);

  exu_state_e             state_q, state_d;
  logic [63:0]            op_a_q, op_a_d, op_b_q, op_b_d;
  logic [63:0]            op_pc_q, op_pc_d, op_imm_q, op_imm_d;
  logic [ALUOP_WIDTH-1:0] op_code_q, op_code_d;
  logic [BRSEL_WIDTH-1:0] op_brsel_q, op_brsel_d;
  logic                   alu_start_q, alu_start_d, mul_start_q, mul_start_d;
  logic                   div_start_q, div_start_d, div_signed_q, div_signed_d;
  logic [63:0]            wb_data_q, wb_data_d, wb_target_q, wb_target_d;
  logic                   wb_redirect_q, wb_redirect_d, wb_err_q, wb_err_d;

  logic accept, pending_ok, ctr_en, ctr_expired;

  assign issue_ready = (state_q == IDLE) && !flush;
  assign accept      = issue_valid && issue_ready;
  assign busy        = (state_q != IDLE);
  assign wb_valid    = (state_q == DONE) && !flush;
  assign ctr_en      = (state_q == MUL_WAIT) || (state_q == DIV_WAIT) || (state_q == DRAIN);
  assign pending_ok  = (op_unit(op_code_q) == UNIT_MUL) ? mul_ok : div_ok;

  exu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );

  // Next state, operand latching, start pulses and result capture.
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_pc_d       = op_pc_q;
    op_imm_d      = op_imm_q;
    op_code_d     = op_code_q;
    op_brsel_d    = op_brsel_q;
    div_signed_d  = div_signed_q;
    alu_start_d   = 1'b0;
    mul_start_d   = 1'b0;
    div_start_d   = 1'b0;
    wb_data_d     = wb_data_q;
    wb_target_d   = wb_target_q;
    wb_redirect_d = wb_redirect_q;
    wb_err_d      = wb_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d       = issue_a;
          op_b_d       = issue_b;
          op_pc_d      = issue_pc;
          op_imm_d     = issue_imm;
          op_code_d    = issue_op;
          op_brsel_d   = issue_brsel;
          div_signed_d = op_div_signed(issue_op);
          case (op_unit(issue_op))
            UNIT_MUL: begin
              state_d     = MUL_WAIT;
              mul_start_d = 1'b1;
            end
            UNIT_DIV: begin
              state_d     = DIV_WAIT;
              div_start_d = 1'b1;
            end
            default: begin
              state_d     = ALU_WAIT;
              alu_start_d = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ALU_WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (alu_ok) begin
          state_d       = DONE;
          wb_data_d     = alu_res;
          wb_target_d   = br_res;
          wb_redirect_d = br_redirect && (op_brsel_q != {BRSEL_WIDTH{1'b0}});
          wb_err_d      = 1'b0;
        end else begin
          state_d = ALU_WAIT;
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        if (flush) begin
          state_d = pending_ok ? IDLE : DRAIN;
        end else if (pending_ok) begin
          state_d       = DONE;
          wb_target_d   = br_res;
          wb_redirect_d = 1'b0;
          wb_err_d      = 1'b0;
          if (state_q == MUL_WAIT) begin
            wb_data_d = mul_res;
          end else if (op_is_rem(op_code_q)) begin
            wb_data_d = div_rem;
          end else begin
            wb_data_d = div_quot;
          end
        end else if (ctr_expired) begin
          state_d       = DONE;
          wb_data_d     = 64'd0;
          wb_target_d   = 64'd0;
          wb_redirect_d = 1'b0;
          wb_err_d      = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (wb_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (pending_ok || ctr_expired) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and output registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_a_q        <= 64'd0;
      op_b_q        <= 64'd0;
      op_pc_q       <= 64'd0;
      op_imm_q      <= 64'd0;
      op_code_q     <= {ALUOP_WIDTH{1'b0}};
      op_brsel_q    <= {BRSEL_WIDTH{1'b0}};
      alu_start_q   <= 1'b0;
      mul_start_q   <= 1'b0;
      div_start_q   <= 1'b0;
      div_signed_q  <= 1'b0;
      wb_data_q     <= 64'd0;
      wb_target_q   <= 64'd0;
      wb_redirect_q <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_pc_q       <= op_pc_d;
      op_imm_q      <= op_imm_d;
      op_code_q     <= op_code_d;
      op_brsel_q    <= op_brsel_d;
      alu_start_q   <= alu_start_d;
      mul_start_q   <= mul_start_d;
      div_start_q   <= div_start_d;
      div_signed_q  <= div_signed_d;
      wb_data_q     <= wb_data_d;
      wb_target_q   <= wb_target_d;
      wb_redirect_q <= wb_redirect_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_pc       = op_pc_q;
  assign op_imm      = op_imm_q;
  assign op_code     = op_code_q;
  assign op_brsel    = op_brsel_q;
  assign alu_start   = alu_start_q;
  assign mul_start   = mul_start_q;
  assign div_start   = div_start_q;
  assign div_signed  = div_signed_q;
  assign wb_data     = wb_data_q;
  assign wb_target   = wb_target_q;
  assign wb_redirect = wb_redirect_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_exu_ctrl.sv
// Self-checking bench for exu_ctrl: directed scenarios plus randomized ops
// checked against a cycle-count / result-selection model of the controller.
module tb_exu_ctrl;
  import exu_ctrl_pkg::*;

  localparam int TMO = 200;

  logic clk, rst;
  logic issue_valid, issue_ready, flush;
  logic [4:0] issue_op, op_code;
  logic [2:0] issue_brsel, op_brsel;
  logic [63:0] issue_a, issue_b, issue_pc, issue_imm;
  logic [63:0] op_a, op_b, op_pc, op_imm;
  logic alu_start, mul_start, div_start, div_signed;
  logic alu_ok, mul_ok, div_ok, br_redirect;
  logic [63:0] alu_res, br_res, mul_res, div_quot, div_rem;
  logic wb_valid, wb_ready, wb_redirect, wb_err, busy;
  logic [63:0] wb_data, wb_target;

  int n_cmp = 0;
  int n_bad = 0;

  // results of the most recent run_op
  int r_lat, r_nalu, r_nmul, r_ndiv;
  logic [63:0] r_data, r_target;
  logic r_err, r_red, r_dsig, r_ops_ok, r_stable;
  logic [63:0] s_alu, s_mul, s_quot, s_rem, s_br;
  logic s_red;

  exu_ctrl #(.MUL_LAT(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_brsel(issue_brsel), .issue_a(issue_a), .issue_b(issue_b),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .flush(flush),
    .op_a(op_a), .op_b(op_b), .op_pc(op_pc), .op_imm(op_imm), .op_code(op_code),
    .op_brsel(op_brsel), .alu_start(alu_start), .mul_start(mul_start), .div_start(div_start),
    .div_signed(div_signed), .alu_ok(alu_ok), .alu_res(alu_res), .br_res(br_res),
    .br_redirect(br_redirect), .mul_ok(mul_ok), .mul_res(mul_res), .div_ok(div_ok),
    .div_quot(div_quot), .div_rem(div_rem), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_redirect(wb_redirect), .wb_target(wb_target), .wb_err(wb_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // model: 0 = ALU, 1 = multiplier, 2 = divider
  function automatic int exp_unit(input logic [4:0] op);
    if (op == 5'd15) return 1;
    if (op >= 5'd16 && op <= 5'd19) return 2;
    return 0;
  endfunction

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_op = 5'd0; issue_brsel = 3'd0;
    issue_a = 64'd0; issue_b = 64'd0; issue_pc = 64'd0; issue_imm = 64'd0;
    flush = 1'b0; alu_ok = 1'b0; mul_ok = 1'b0; div_ok = 1'b0; br_redirect = 1'b0;
    alu_res = 64'd0; br_res = 64'd0; mul_res = 64'd0; div_quot = 64'd0; div_rem = 64'd0;
    wb_ready = 1'b0;
  endtask

  // Issue one op, pulse the serving unit's ok ok_dly cycles after the start
  // cycle (-1: never), toggle the other units' oks randomly, then hold
  // wb_ready low for 'hold' valid cycles before the handshake.
  task automatic run_op(input logic [4:0] op, input logic [2:0] brsel,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] pc, input logic [63:0] imm,
                        input int ok_dly, input int hold,
                        input bit use_fix, input logic [63:0] fix_rem);
    int unit;
    unit = exp_unit(op);
    r_lat = -1; r_nalu = 0; r_nmul = 0; r_ndiv = 0;
    r_dsig = 1'b0; r_ops_ok = 1'b1; r_stable = 1'b1;
    r_data = 64'd0; r_target = 64'd0; r_err = 1'b0; r_red = 1'b0;
    s_alu = 64'd0; s_mul = 64'd0; s_quot = 64'd0; s_rem = 64'd0; s_br = 64'd0; s_red = 1'b0;
    issue_valid = 1'b1; issue_op = op; issue_brsel = brsel;
    issue_a = a; issue_b = b; issue_pc = pc; issue_imm = imm; wb_ready = 1'b0;
    @(negedge clk);
    if (issue_ready !== 1'b1) r_ops_ok = 1'b0;
    next_drive();
    issue_valid = 1'b0; issue_op = 5'($urandom); issue_brsel = 3'($urandom);
    issue_a = rnd64(); issue_b = rnd64(); issue_pc = rnd64(); issue_imm = rnd64();
    for (int cyc = 1; cyc <= TMO + 10 && r_lat < 0; cyc++) begin
      alu_res = rnd64(); mul_res = rnd64(); div_quot = rnd64();
      div_rem = use_fix ? fix_rem : rnd64(); br_res = rnd64(); br_redirect = 1'($urandom);
      alu_ok = (unit == 0) ? (cyc - 1 == ok_dly) : 1'($urandom);
      mul_ok = (unit == 1) ? (cyc - 1 == ok_dly) : 1'($urandom);
      div_ok = (unit == 2) ? (cyc - 1 == ok_dly) : 1'($urandom);
      wb_ready = (hold == 0);
      if (cyc - 1 == ok_dly) begin
        s_alu = alu_res; s_mul = mul_res; s_quot = div_quot; s_rem = div_rem;
        s_br = br_res; s_red = br_redirect;
      end
      @(negedge clk);
      r_nalu += int'(alu_start); r_nmul += int'(mul_start); r_ndiv += int'(div_start);
      if (div_start) r_dsig = div_signed;
      if ({op_a, op_b, op_pc, op_imm} !== {a, b, pc, imm} || op_code !== op || op_brsel !== brsel)
        r_ops_ok = 1'b0;
      if (wb_valid === 1'b1) begin
        r_lat = cyc; r_data = wb_data; r_target = wb_target; r_err = wb_err; r_red = wb_redirect;
      end
      next_drive();
    end
    alu_ok = 1'b0; mul_ok = 1'b0; div_ok = 1'b0;
    if (r_lat >= 0 && hold > 0) begin
      for (int h = 1; h <= hold; h++) begin
        wb_ready = (h == hold);
        @(negedge clk);
        if (wb_valid !== 1'b1 || wb_data !== r_data || wb_target !== r_target ||
            wb_err !== r_err || wb_redirect !== r_red || issue_ready !== 1'b0)
          r_stable = 1'b0;
        next_drive();
      end
    end
    wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, wb_valid, wb_err, wb_redirect, alu_start, mul_start, div_start, div_signed} !== 8'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000000",
        {busy, wb_valid, wb_err, wb_redirect, alu_start, mul_start, div_start, div_signed});
    end
    n_cmp++;
    if ((wb_data | wb_target | op_a | op_b | op_pc | op_imm) !== 64'd0 || op_code !== 5'd0 || op_brsel !== 3'd0) begin
      n_bad++; $display("FAIL reset_data: got wb_data=%h op_a=%h expected 0", wb_data, op_a);
    end
    n_cmp++;
    if (issue_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b expected 1", issue_ready);
    end
    rst = 1'b1;
    next_drive();
    alu_ok = 1'b1; mul_ok = 1'b1; div_ok = 1'b1;
    next_drive();
    alu_ok = 1'b0; mul_ok = 1'b0; div_ok = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_ok_ignored: got busy=%b wb_valid=%b expected 0 0", busy, wb_valid);
    end
    next_drive();
  endtask

  task automatic test_alu();
    run_op(OP_ADD, 3'd0, rnd64(), rnd64(), rnd64(), rnd64(), 0, 0, 1'b0, 64'd0);
    n_cmp++;
    if (r_lat !== 2) begin n_bad++; $display("FAIL alu_latency: got %0d expected 2", r_lat); end
    n_cmp++;
    if (r_nalu !== 1 || r_nmul !== 0 || r_ndiv !== 0) begin
      n_bad++; $display("FAIL alu_starts: got %0d/%0d/%0d expected 1/0/0", r_nalu, r_nmul, r_ndiv);
    end
    n_cmp++;
    if (r_data !== s_alu || r_err !== 1'b0) begin
      n_bad++; $display("FAIL alu_data: got %h err=%b expected %h err=0", r_data, r_err, s_alu);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL alu_idle: got busy=%b expected 0", busy); end
    next_drive();
  endtask

  task automatic test_div_rem();
    run_op(OP_REM, 3'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, rnd64(), rnd64(), 10, 0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF);
    n_cmp++;
    if (r_dsig !== 1'b1 || r_ndiv !== 1) begin
      n_bad++; $display("FAIL rem_signed: got dsig=%b starts=%0d expected 1 1", r_dsig, r_ndiv);
    end
    n_cmp++;
    if (r_data !== 64'hFFFF_FFFF_FFFF_FFFF || r_err !== 1'b0 || r_lat !== 12) begin
      n_bad++; $display("FAIL rem_data: got %h err=%b lat=%0d expected ffffffffffffffff 0 12",
                        r_data, r_err, r_lat);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [4:0] op;
      logic [2:0] brsel;
      int unit, dly, hold, nstart_exp;
      logic [63:0] exp_data;
      logic exp_red;
      case ($urandom_range(0, 2))
        0: begin
          op = 5'($urandom_range(0, 31));
          while (op >= 5'd15 && op <= 5'd19) op = 5'($urandom_range(0, 31));
        end
        1: op = 5'd15;
        default: op = 5'(16 + $urandom_range(0, 3));
      endcase
      brsel = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      dly = $urandom_range(0, 6);
      hold = $urandom_range(0, 3);
      unit = exp_unit(op);
      run_op(op, brsel, rnd64(), rnd64(), rnd64(), rnd64(), dly, hold, 1'b0, 64'd0);
      exp_red = 1'b0;
      if (unit == 0) begin exp_data = s_alu; exp_red = s_red && (brsel != 3'd0); end
      else if (unit == 1) exp_data = s_mul;
      else exp_data = (op == 5'd18 || op == 5'd19) ? s_rem : s_quot;
      n_cmp++;
      if (r_lat !== dly + 2) begin
        n_bad++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, r_lat, dly + 2);
      end
      n_cmp++;
      if (r_data !== exp_data || r_red !== exp_red || r_target !== s_br || r_err !== 1'b0) begin
        n_bad++; $display("FAIL rnd_result[%0d] op=%0d: got %h red=%b tgt=%h err=%b expected %h red=%b tgt=%h err=0",
                          i, op, r_data, r_red, r_target, r_err, exp_data, exp_red, s_br);
      end
      nstart_exp = (unit == 0) ? 100 : (unit == 1) ? 10 : 1;
      n_cmp++;
      if (r_nalu * 100 + r_nmul * 10 + r_ndiv !== nstart_exp) begin
        n_bad++; $display("FAIL rnd_starts[%0d]: got %0d/%0d/%0d expected code %0d",
                          i, r_nalu, r_nmul, r_ndiv, nstart_exp);
      end
      if (unit == 2) begin
        n_cmp++;
        if (r_dsig !== (op == 5'd16 || op == 5'd18)) begin
          n_bad++; $display("FAIL rnd_divsigned[%0d] op=%0d: got %b", i, op, r_dsig);
        end
      end
      n_cmp++;
      if (r_ops_ok !== 1'b1 || r_stable !== 1'b1) begin
        n_bad++; $display("FAIL rnd_hold[%0d]: got ops_ok=%b stable=%b expected 1 1", i, r_ops_ok, r_stable);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle[%0d]: got busy=%b expected 0", i, busy); end
      next_drive();
    end
  endtask

  task automatic test_timeout();
    run_op(OP_DIVU, 3'd1, rnd64(), 64'd0, rnd64(), rnd64(), -1, 0, 1'b0, 64'd0);
    n_cmp++;
    if (r_lat !== TMO + 1 || r_err !== 1'b1 || r_data !== 64'd0 || r_red !== 1'b0) begin
      n_bad++; $display("FAIL divu_timeout: got lat=%0d err=%b data=%h red=%b expected %0d 1 0 0",
                        r_lat, r_err, r_data, r_red, TMO + 1);
    end
    run_op(OP_MUL, 3'd0, rnd64(), rnd64(), rnd64(), rnd64(), TMO - 1, 0, 1'b0, 64'd0);
    n_cmp++;
    if (r_lat !== TMO + 1 || r_err !== 1'b0 || r_data !== s_mul) begin
      n_bad++; $display("FAIL ok_at_timeout: got lat=%0d err=%b data=%h expected %0d 0 %h",
                        r_lat, r_err, r_data, TMO + 1, s_mul);
    end
    run_op(OP_MUL, 3'd0, rnd64(), rnd64(), rnd64(), rnd64(), TMO, 0, 1'b0, 64'd0);
    n_cmp++;
    if (r_lat !== TMO + 1 || r_err !== 1'b1 || r_data !== 64'd0) begin
      n_bad++; $display("FAIL ok_after_timeout: got lat=%0d err=%b data=%h expected %0d 1 0",
                        r_lat, r_err, r_data, TMO + 1);
    end
  endtask

  task automatic test_flush();
    logic saw_valid;
    saw_valid = 1'b0;
    // multiplier flushed in its start cycle, ok two cycles later
    issue_valid = 1'b1; issue_op = OP_MUL; issue_a = rnd64();
    @(negedge clk);
    next_drive();
    issue_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    saw_valid |= wb_valid;
    next_drive();
    flush = 1'b0;
    @(negedge clk);
    saw_valid |= wb_valid;
    n_cmp++;
    if (busy !== 1'b1 || issue_ready !== 1'b0) begin
      n_bad++; $display("FAIL drain_entry: got busy=%b ready=%b expected 1 0", busy, issue_ready);
    end
    next_drive();
    mul_ok = 1'b1; issue_valid = 1'b1; issue_op = OP_ADD;
    @(negedge clk);
    saw_valid |= wb_valid;
    n_cmp++;
    if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL drain_ready: got %b expected 0", issue_ready); end
    next_drive();
    mul_ok = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    saw_valid |= wb_valid;
    n_cmp++;
    if (busy !== 1'b0 || issue_ready !== 1'b1 || op_code !== OP_MUL) begin
      n_bad++; $display("FAIL drain_exit: got busy=%b ready=%b op=%0d expected 0 1 15", busy, issue_ready, op_code);
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL drain_no_wb: got wb_valid seen=%b expected 0", saw_valid); end
    next_drive();
    // flush together with the multiplier ok: straight back to idle
    issue_valid = 1'b1; issue_op = OP_MUL;
    @(negedge clk);
    next_drive();
    issue_valid = 1'b0; flush = 1'b1; mul_ok = 1'b1;
    @(negedge clk);
    next_drive();
    flush = 1'b0; mul_ok = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_with_ok: got busy=%b wb_valid=%b expected 0 0", busy, wb_valid);
    end
    next_drive();
    // flush while the result waits in DONE
    issue_valid = 1'b1; issue_op = OP_ADD;
    @(negedge clk);
    next_drive();
    issue_valid = 1'b0; alu_ok = 1'b1;
    next_drive();
    alu_ok = 1'b0; flush = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL done_flush: got wb_valid=%b busy=%b expected 0 1", wb_valid, busy);
    end
    next_drive();
    flush = 1'b0; wb_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL done_flush_idle: got busy=%b expected 0", busy); end
    next_drive();
  endtask

  task automatic test_back_to_back();
    logic [63:0] a1, a2, res;
    logic stable;
    a1 = rnd64(); a2 = ~a1; res = rnd64(); stable = 1'b1;
    issue_valid = 1'b1; issue_op = OP_ADD; issue_a = a1;
    @(negedge clk);
    next_drive();
    issue_op = 5'd1; issue_a = a2; alu_ok = 1'b1; alu_res = res;
    next_drive();
    alu_ok = 1'b0; alu_res = rnd64();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_data !== res || issue_ready !== 1'b0 || op_a !== a1) stable = 1'b0;
      next_drive();
    end
    n_cmp++;
    if (stable !== 1'b1) begin n_bad++; $display("FAIL backpressure_hold: got stable=%b expected 1", stable); end
    wb_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_data !== res) begin
      n_bad++; $display("FAIL handshake: got wb_valid=%b data=%h expected 1 %h", wb_valid, wb_data, res);
    end
    next_drive();
    wb_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL second_accept: got ready=%b expected 1", issue_ready); end
    next_drive();
    issue_valid = 1'b0; alu_ok = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (alu_start !== 1'b1 || op_a !== a2 || op_code !== 5'd1) begin
      n_bad++; $display("FAIL second_op: got start=%b op_a=%h op=%0d expected 1 %h 1", alu_start, op_a, op_code, a2);
    end
    next_drive();
    alu_ok = 1'b0;
    next_drive();
    wb_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL second_done: got busy=%b expected 0", busy); end
    next_drive();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_op = OP_DIVU; issue_a = rnd64() | 64'd1;
    @(negedge clk);
    next_drive();
    issue_valid = 1'b0;
    next_drive();
    next_drive();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, div_start, div_signed, wb_valid, wb_err, wb_redirect} !== 6'd0 ||
        (op_a | wb_data | wb_target) !== 64'd0 || op_code !== 5'd0) begin
      n_bad++; $display("FAIL mid_reset: got busy=%b op_a=%h op=%0d wb_data=%h expected all 0",
                        busy, op_a, op_code, wb_data);
    end
    next_drive();
    rst = 1'b1;
    next_drive();
    div_ok = 1'b1; div_quot = rnd64();
    next_drive();
    div_ok = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 64'd0) begin
      n_bad++; $display("FAIL stale_div_ok: got busy=%b wb_valid=%b data=%h expected 0 0 0", busy, wb_valid, wb_data);
    end
    next_drive();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_alu();
    test_div_rem();
    test_random();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
